hmc_tag_pool: RTL and testbench
===============================

Name: hmc_tag_pool

Overview:
- Issue stage directly upstream of the HMC response reorder stage.
- Accepts untagged HMC requests from user logic and stamps each with a free tag from a hardware free list.
- Presents tagged commands on the cmd/cmd_valid/cmd_ready/tag/size interface that the controller and the reorder stage snoop.
- Retires a tag after its last response beat, so no tag is ever reused while responses for it are still in flight.

Parameters:
ID_WIDTH, 6, tag width; pool holds NUM_TAGS = 2^ID_WIDTH tags
ADDR_WIDTH, 34, request address width, passed through unchanged

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  1  user request valid
req_ready  out  1  user request accepted when req_valid & req_ready
req_cmd  in  4  HMC command code
req_size  in  4  request size field
req_addr  in  ADDR_WIDTH  request address
req_rsp_beats  in  4  expected response beats, 1..8; 0 = posted, no response
cmd_valid  out  1  tagged command valid
cmd_ready  in  1  controller accepts command
cmd  out  4  registered req_cmd
size  out  4  registered req_size
addr  out  ADDR_WIDTH  registered req_addr
tag  out  ID_WIDTH  assigned tag
rsp_valid  in  1  one response data beat
rsp_tag  in  ID_WIDTH  tag of that beat
tags_free  out  ID_WIDTH+1  tags currently in free list
init_done  out  1  free list populated
err_rsp  out  1  one-cycle pulse: beat for a tag not outstanding

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- Reset values: cmd_valid=0, req_ready=0, init_done=0, tags_free=0, err_rsp=0, cmd/size/addr/tag=0.
- Reset clears all outstanding bits, free-list pointers and the state machine, including mid-operation.
- States:
  - INIT: entered on reset. Writes tags 0..NUM_TAGS-1 into the free-list FIFO, one per cycle, in ascending order. tags_free increments each cycle. After NUM_TAGS cycles go to RUN and set init_done=1.
  - RUN: normal operation. Never leaves RUN except by rst.
- Free list:
  - FIFO of depth NUM_TAGS with ID_WIDTH+1-bit read/write pointers.
  - It cannot overflow, because only NUM_TAGS distinct tags exist.
  - Head tag is visible combinationally.
- Acceptance:
  - req_ready = RUN & (tags_free != 0) & (!cmd_valid | cmd_ready).
  - Posted requests (req_rsp_beats == 0) do not require a free tag: req_ready = RUN & (!cmd_valid | cmd_ready).
- Issue, on accept, next cycle:
  - cmd_valid=1; cmd/size/addr load from the request; tag loads the free-list head.
  - Non-posted: pop the head, set outstanding[tag]=1, beats_left[tag]=req_rsp_beats.
  - Posted: head is used as the tag value but not popped; no outstanding state is recorded.
- Output hold: cmd_valid and all fields stay stable until cmd_ready. A new request may load in the same cycle cmd_ready is seen, giving full throughput of one command per cycle.
- Latency: one cycle, request accept to cmd_valid.
- Response, per beat with rsp_valid=1:
  - If outstanding[rsp_tag]=0: pulse err_rsp for one cycle and change no state.
  - Else if beats_left==1: clear outstanding and push rsp_tag to the free list.
  - Else: decrement beats_left.
  - beats_left is 4 bits; it never decrements below 1 while outstanding.
- Simultaneous push and pop: allowed; tags_free stays unchanged.
- A pushed tag is poppable no earlier than the cycle after the push.
- tags_free updates as +push −pop each cycle.
- Pool exhausted (tags_free==0): non-posted requests stall with req_ready=0. Posted requests still flow.
- Responses arriving during INIT are treated as unexpected: err_rsp pulses.
- Overlap with issue: a response beat for a tag whose command is still held in the cmd register (not yet accepted) is legal, since outstanding was set at load.

Test Plan:
- Reset, then idle NUM_TAGS=64 cycles -> init_done=1 at cycle 64, tags_free=64, req_ready=1 with req_valid high; first four accepted requests get tag=0,1,2,3.
- 64 back-to-back non-posted reads, req_rsp_beats=2, cmd_ready=1 -> one cmd per cycle, tags 0..63, tags_free=0, req_ready=0 on the 65th request; two beats for tag 5 -> tags_free=1, next issued tag=5.
- Posted write while tags_free=0 -> accepted; cmd_valid next cycle with tag equal to the current head; tags_free stays 0.
- cmd_ready held low 10 cycles with cmd_valid=1 -> cmd/size/addr/tag stable, req_ready=0; cmd_ready high -> pending command and next request advance in consecutive cycles.
- rsp_valid for tag 9 that was never issued, and a third beat for a 2-beat tag -> err_rsp one-cycle pulse each; tags_free unchanged.
- rst asserted with 20 tags outstanding and cmd_valid=1 -> next cycle cmd_valid=0, tags_free=0, init_done=0; re-init completes after 64 cycles with all 64 tags free.

Source files
------------

// File: rtl/hmc_tag_pool.sv
// HMC request issue stage: stamps each request with a tag from a hardware free list
// and retires the tag once its final response beat has been seen.
module hmc_tag_pool #(
   parameter int ID_WIDTH   = 6,
   parameter int ADDR_WIDTH = 34
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [3:0]            req_cmd,
   input  logic [3:0]            req_size,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [3:0]            req_rsp_beats,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic [3:0]            cmd,
   output logic [3:0]            size,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [ID_WIDTH-1:0]   tag,
   input  logic                  rsp_valid,
   input  logic [ID_WIDTH-1:0]   rsp_tag,
   output logic [ID_WIDTH:0]     tags_free,
   output logic                  init_done,
   output logic                  err_rsp
);

   localparam int NUM_TAGS = 1 << ID_WIDTH;
   localparam logic [ID_WIDTH-1:0] ID_ONE  = {{(ID_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ID_WIDTH:0]   PTR_ONE = {{ID_WIDTH{1'b0}}, 1'b1};
   localparam logic [ID_WIDTH-1:0] ID_LAST = {ID_WIDTH{1'b1}};

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [ID_WIDTH-1:0]     init_cnt_r;
   logic [ID_WIDTH-1:0]     fl_mem_r [NUM_TAGS];
   logic [ID_WIDTH:0]       rd_ptr_r;
   logic [ID_WIDTH:0]       wr_ptr_r;
   logic [ID_WIDTH:0]       tags_free_r;
   logic [NUM_TAGS-1:0]     outstanding_r;
   logic [3:0]              beats_left_r [NUM_TAGS];
   logic                    cmd_valid_r;
   logic [3:0]              cmd_r;
   logic [3:0]              size_r;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [ID_WIDTH-1:0]     tag_r;
   logic                    init_done_r;
   logic                    err_rsp_r;

   logic                    run_s;
   logic                    posted_s;
   logic                    req_ready_s;
   logic                    load_s;
   logic                    pop_s;
   logic [ID_WIDTH-1:0]     head_s;
   logic                    rsp_hit_s;
   logic                    rsp_last_s;
   logic                    push_s;
   logic [ID_WIDTH-1:0]     push_tag_s;

   // Next-state logic: INIT fills the free list, RUN is left only through rst
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_INIT: begin
            if (init_cnt_r == ID_LAST) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_INIT;
            end
         end
         ST_RUN:  state_nxt_s = ST_RUN;
         default: state_nxt_s = ST_INIT;
      endcase
   end

   // Handshake, free-list and response decode
   always_comb begin
      run_s       = (state_r == ST_RUN);
      posted_s    = (req_rsp_beats == 4'd0);
      // posted requests borrow the head value without consuming it
      req_ready_s = run_s & (~cmd_valid_r | cmd_ready) &
                    (posted_s | (tags_free_r != {(ID_WIDTH+1){1'b0}}));
      load_s      = req_valid & req_ready_s;
      pop_s       = load_s & ~posted_s;
      head_s      = fl_mem_r[rd_ptr_r[ID_WIDTH-1:0]];
      rsp_hit_s   = run_s & rsp_valid & outstanding_r[rsp_tag];
      rsp_last_s  = rsp_hit_s & (beats_left_r[rsp_tag] == 4'd1);
      if (state_r == ST_INIT) begin
         push_s     = 1'b1;
         push_tag_s = init_cnt_r;
      end else begin
         push_s     = rsp_last_s;
         push_tag_s = rsp_tag;
      end
   end

   // State, free list, per-tag tracking and registered command outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_INIT;
         init_cnt_r    <= {ID_WIDTH{1'b0}};
         rd_ptr_r      <= {(ID_WIDTH+1){1'b0}};
         wr_ptr_r      <= {(ID_WIDTH+1){1'b0}};
         tags_free_r   <= {(ID_WIDTH+1){1'b0}};
         outstanding_r <= {NUM_TAGS{1'b0}};
         init_done_r   <= 1'b0;
         err_rsp_r     <= 1'b0;
         cmd_valid_r   <= 1'b0;
         cmd_r         <= 4'd0;
         size_r        <= 4'd0;
         addr_r        <= {ADDR_WIDTH{1'b0}};
         tag_r         <= {ID_WIDTH{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         init_done_r <= (state_nxt_s == ST_RUN);
         err_rsp_r   <= rsp_valid & ~rsp_hit_s;
         if (state_r == ST_INIT) begin
            init_cnt_r <= init_cnt_r + ID_ONE;
         end
         if (push_s) begin
            fl_mem_r[wr_ptr_r[ID_WIDTH-1:0]] <= push_tag_s;
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         tags_free_r <= tags_free_r + {{ID_WIDTH{1'b0}}, push_s} - {{ID_WIDTH{1'b0}}, pop_s};
         // a popped tag can never equal an outstanding rsp_tag, so these writes never collide
         if (rsp_hit_s) begin
            if (rsp_last_s) begin
               outstanding_r[rsp_tag] <= 1'b0;
            end else begin
               beats_left_r[rsp_tag] <= beats_left_r[rsp_tag] - 4'd1;
            end
         end
         if (pop_s) begin
            outstanding_r[head_s] <= 1'b1;
            beats_left_r[head_s]  <= req_rsp_beats;
         end
         if (load_s) begin
            cmd_valid_r <= 1'b1;
            cmd_r       <= req_cmd;
            size_r      <= req_size;
            addr_r      <= req_addr;
            tag_r       <= head_s;
         end else if (cmd_ready) begin
            cmd_valid_r <= 1'b0;
         end
      end
   end

   assign req_ready = req_ready_s;
   assign cmd_valid = cmd_valid_r;
   assign cmd       = cmd_r;
   assign size      = size_r;
   assign addr      = addr_r;
   assign tag       = tag_r;
   assign tags_free = tags_free_r;
   assign init_done = init_done_r;
   assign err_rsp   = err_rsp_r;

endmodule

// File: tb/tb_hmc_tag_pool.sv
// Scoreboard bench for hmc_tag_pool: a free-list reference model predicts tags and
// status, expected commands are queued on accept and compared on cmd handshake.
module tb_hmc_tag_pool;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_cmd = 4'd0;
   logic [3:0]  req_size = 4'd0;
   logic [33:0] req_addr = 34'd0;
   logic [3:0]  req_rsp_beats = 4'd0;
   logic        cmd_valid;
   logic        cmd_ready = 1'b1;
   logic [3:0]  cmd;
   logic [3:0]  size;
   logic [33:0] addr;
   logic [5:0]  tag;
   logic        rsp_valid = 1'b0;
   logic [5:0]  rsp_tag = 6'd0;
   logic [6:0]  tags_free;
   logic        init_done;
   logic        err_rsp;

   hmc_tag_pool #(.ID_WIDTH(6), .ADDR_WIDTH(34)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
      .req_size(req_size), .req_addr(req_addr), .req_rsp_beats(req_rsp_beats),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .size(size),
      .addr(addr), .tag(tag), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag),
      .tags_free(tags_free), .init_done(init_done), .err_rsp(err_rsp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  cmd;
      logic [3:0]  size;
      logic [33:0] addr;
      logic [5:0]  tag;
   } exp_t;

   exp_t sb[$];
   int   seen[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // reference model of the free list and tag tracking
   logic [5:0]  m_mem [64];
   logic [3:0]  m_beats [64];
   logic [63:0] m_out;
   logic [6:0]  m_rd, m_wr, m_free;
   logic [5:0]  m_icnt;
   bit          m_run, m_cmd_valid, m_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 1'b0; m_cmd_valid = 1'b0; m_err = 1'b0;
      m_rd = 7'd0; m_wr = 7'd0; m_free = 7'd0; m_icnt = 6'd0; m_out = 64'd0;
      sb.delete();
      seen.delete();
   endtask

   // one clock: called at negedge with inputs driven, returns at the next negedge
   task automatic tick();
      bit         posted, exp_ready, load, pop, push, hit;
      logic [5:0] head, ptag;
      exp_t       e;
      #1;
      posted    = (req_rsp_beats == 4'd0);
      exp_ready = m_run && (!m_cmd_valid || cmd_ready) && (posted || m_free != 7'd0);
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("cmd_valid", 64'(cmd_valid), 64'(m_cmd_valid));
      check("tags_free", 64'(tags_free), 64'(m_free));
      check("init_done", 64'(init_done), 64'(m_run));
      check("err_rsp", 64'(err_rsp), 64'(m_err));
      if (cmd_valid && cmd_ready) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_cmd", 64'(1), 64'(0));
         end else begin
            e = sb.pop_front();
            check("cmd_cmd", 64'(cmd), 64'(e.cmd));
            check("cmd_size", 64'(size), 64'(e.size));
            check("cmd_addr", 64'(addr), 64'(e.addr));
            check("cmd_tag", 64'(tag), 64'(e.tag));
            seen.push_back(int'(tag));
         end
      end
      head = m_mem[m_rd[5:0]];
      load = req_valid && exp_ready;
      pop  = load && !posted;
      hit  = m_run && rsp_valid && m_out[rsp_tag];
      push = 1'b0;
      ptag = 6'd0;
      if (!m_run) begin
         push = 1'b1;
         ptag = m_icnt;
      end else if (hit) begin
         if (m_beats[rsp_tag] == 4'd1) begin
            m_out[rsp_tag] = 1'b0;
            push = 1'b1;
            ptag = rsp_tag;
         end else begin
            m_beats[rsp_tag] = m_beats[rsp_tag] - 4'd1;
         end
      end
      m_err = rsp_valid && !hit;
      if (push) begin
         m_mem[m_wr[5:0]] = ptag;
         m_wr = m_wr + 7'd1;
      end
      if (pop) begin
         m_rd = m_rd + 7'd1;
         m_out[head] = 1'b1;
         m_beats[head] = req_rsp_beats;
      end
      m_free = m_free + 7'(push) - 7'(pop);
      if (load) begin
         e.cmd = req_cmd; e.size = req_size; e.addr = req_addr; e.tag = head;
         sb.push_back(e);
         m_cmd_valid = 1'b1;
      end else if (cmd_ready) begin
         m_cmd_valid = 1'b0;
      end
      if (!m_run) begin
         if (m_icnt == 6'd63) m_run = 1'b1;
         m_icnt = m_icnt + 6'd1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      req_valid = 1'b0;
      rsp_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_cmd_valid", 64'(cmd_valid), 64'(0));
      check("rst_req_ready", 64'(req_ready), 64'(0));
      check("rst_init_done", 64'(init_done), 64'(0));
      check("rst_tags_free", 64'(tags_free), 64'(0));
      check("rst_err_rsp", 64'(err_rsp), 64'(0));
      check("rst_fields", {50'(0), cmd, size, tag}, 64'(0));
      check("rst_addr", 64'(addr), 64'(0));
      rst = 1'b0;
      model_reset();
   endtask

   task automatic wait_init();
      int n = 0;
      while (!init_done && n < 200) begin
         tick();
         n++;
      end
      check("init_cycles", 64'(n), 64'(64));
      check("init_tags_free", 64'(tags_free), 64'(64));
   endtask

   task automatic rsp_beat(input logic [5:0] t);
      rsp_valid = 1'b1;
      rsp_tag   = t;
      tick();
      rsp_valid = 1'b0;
   endtask

   task automatic set_req(input logic [3:0] c, input logic [3:0] beats);
      req_valid     = 1'b1;
      req_cmd       = c;
      req_size      = 4'($urandom);
      req_addr      = {2'($urandom), $urandom};
      req_rsp_beats = beats;
   endtask

   logic [3:0]  h_cmd, h_size;
   logic [33:0] h_addr;
   logic [5:0]  h_tag;

   initial begin
      model_reset();
      @(negedge clk);
      apply_reset();
      wait_init();

      // beat for a never-issued tag
      rsp_beat(6'd9);
      check("err_unissued", 64'(err_rsp), 64'(1));
      tick();
      check("err_pulse_end", 64'(err_rsp), 64'(0));
      check("err_free_same", 64'(tags_free), 64'(64));

      // 64 back-to-back non-posted reads drain the pool
      cmd_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         set_req(4'h1, 4'd2);
         tick();
      end
      set_req(4'h1, 4'd2);
      #1;
      check("exhaust_ready", 64'(req_ready), 64'(0));
      tick();
      req_valid = 1'b0;
      tick();
      check("exhaust_free", 64'(tags_free), 64'(0));
      check("b2b_count", 64'(seen.size()), 64'(64));
      for (int i = 0; i < 64 && i < seen.size(); i++) begin
         check("b2b_tag", 64'(seen[i]), 64'(i));
      end

      // posted write still flows with an empty pool, using the stale head
      set_req(4'h9, 4'd0);
      #1;
      check("posted_ready", 64'(req_ready), 64'(1));
      tick();
      req_valid = 1'b0;
      tick();
      check("posted_tag", 64'(seen[64]), 64'(0));
      check("posted_free", 64'(tags_free), 64'(0));

      // retire tag 5 and reissue it
      rsp_beat(6'd5);
      rsp_beat(6'd5);
      check("retire_free", 64'(tags_free), 64'(1));
      set_req(4'h1, 4'd2);
      tick();
      req_valid = 1'b0;
      tick();
      check("reissue_tag", 64'(seen[65]), 64'(5));

      // third beat of a two-beat tag is unexpected
      rsp_beat(6'd7);
      rsp_beat(6'd7);
      rsp_beat(6'd7);
      check("err_extra_beat", 64'(err_rsp), 64'(1));
      check("extra_free_same", 64'(tags_free), 64'(1));
      rsp_beat(6'd8);
      rsp_beat(6'd8);
      check("two_free", 64'(tags_free), 64'(2));

      // back-pressure: command held stable, then two commands in consecutive cycles
      cmd_ready = 1'b0;
      set_req(4'h3, 4'd2);
      tick();
      h_cmd = cmd; h_size = size; h_addr = addr; h_tag = tag;
      check("hold_first_tag", 64'(tag), 64'(7));
      set_req(4'h4, 4'd3);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("hold_ready", 64'(req_ready), 64'(0));
         check("hold_fields", {46'(0), cmd, size, tag}, {46'(0), h_cmd, h_size, h_tag});
         check("hold_addr", 64'(addr), 64'(h_addr));
      end
      cmd_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      check("adv_valid", 64'(cmd_valid), 64'(1));
      check("adv_tag", 64'(tag), 64'(8));
      tick();
      check("adv_order0", 64'(seen[66]), 64'(7));
      check("adv_order1", 64'(seen[67]), 64'(8));
      check("adv_idle", 64'(cmd_valid), 64'(0));

      // reset mid-operation with many tags outstanding and a held command
      cmd_ready = 1'b0;
      set_req(4'h9, 4'd0);
      tick();
      check("pre_rst_valid", 64'(cmd_valid), 64'(1));
      check("pre_rst_outstanding", 64'($countones(m_out) >= 20), 64'(1));
      apply_reset();
      cmd_ready = 1'b1;
      wait_init();
      rsp_beat(6'd20);
      check("post_rst_err", 64'(err_rsp), 64'(1));
      set_req(4'h1, 4'd1);
      tick();
      req_valid = 1'b0;
      tick();
      check("post_rst_tag", 64'(seen.size() > 0 ? seen[0] : -1), 64'(0));
      check("sb_drained", 64'(sb.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
